// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
//
// Keeps a shift register of the register writers that have already left EX.
// Slot 1 is EX/MEM, slot 2 is MEM/WB, and so on up to DEPTH. From that state
// it derives:
//   - a bypass select for each EX source operand,
//   - a bypass select for a fixed register (read early by ecall in ID),
//   - the load-use stall request for ID, plus a saturating count of stall cycles.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   advance           pipeline moves past EX this cycle; slots shift
//   ex_*              instruction currently in EX (it enters slot 1 on advance)
//   id_valid, id_rs,  sources read by the instruction in ID
//   id_rs_used
//   fwd_sel           per EX source: 0 = register file, k = bypass from slot k
//   fwd_fixed_sel     youngest slot writing FIXED_REG, 0 = none
//   stall_req         hold IF/ID and inject a bubble into EX
//   stall_count       saturating number of cycles with stall_req set
module fwd_hazard_unit #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FIXED_REG  = 17,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SEL_W      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic                       ex_valid,
  input  logic [REG_W-1:0]           ex_rd,
  input  logic                       ex_reg_write,
  input  logic                       ex_mem_read,
  input  logic [NUM_SRC*REG_W-1:0]   ex_rs,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [SEL_W-1:0]           fwd_fixed_sel,
  output logic                       stall_req,
  output logic [CNT_W-1:0]           stall_count
);

  localparam logic [REG_W-1:0] FixedReg = REG_W'(FIXED_REG);

  // Producer slots, index k = distance past EX.
  logic [DEPTH:1]   valid_q;
  logic [DEPTH:1]   wr_q;
  logic [DEPTH:1]   mr_q;
  logic [REG_W-1:0] rd_q [DEPTH:1];
  logic [CNT_W-1:0] count_q;

  // Only the valid bits need reset; payload is ignored while a slot is invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (advance) begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        valid_q[k] <= valid_q[k-1];
      end
      valid_q[1] <= ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        wr_q[k] <= wr_q[k-1];
        mr_q[k] <= mr_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      wr_q[1] <= ex_reg_write;
      mr_q[1] <= ex_mem_read;
      rd_q[1] <= ex_rd;
    end
  end

  // Bypass selects: scan oldest to youngest so the youngest match is written last.
  always_comb begin
    logic [REG_W-1:0] src;
    src           = '0;
    fwd_sel       = '0;
    fwd_fixed_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src = ex_rs[i*REG_W +: REG_W];
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (valid_q[k] && wr_q[k] && (rd_q[k] == src) && (src != '0)) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (valid_q[k] && wr_q[k] && (rd_q[k] == FixedReg) && (FixedReg != '0)) begin
        fwd_fixed_sel = SEL_W'(k);
      end
    end
  end

  // Load-use: the producer at stage j (0 = EX) can only be bypassed once its
  // consumer reaches EX at stage j+1 >= LOAD_READY. Only the youngest producer
  // of a register matters, so an older load behind a younger ALU write is fine.
  always_comb begin
    logic [REG_W-1:0] src;
    logic             hit;
    logic             is_load;
    int               stage;
    src       = '0;
    hit       = 1'b0;
    is_load   = 1'b0;
    stage     = 0;
    stall_req = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src     = id_rs[i*REG_W +: REG_W];
      hit     = 1'b0;
      is_load = 1'b0;
      stage   = 0;
      for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
        if (valid_q[j] && wr_q[j] && (rd_q[j] == src) && (src != '0)) begin
          hit     = 1'b1;
          is_load = mr_q[j];
          stage   = j;
        end
      end
      if (ex_valid && ex_reg_write && (ex_rd == src) && (src != '0)) begin
        hit     = 1'b1;
        is_load = ex_mem_read;
        stage   = 0;
      end
      if (id_valid && id_rs_used[i] && hit && is_load && (stage + 1 < int'(LOAD_READY))) begin
        stall_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (stall_req && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign stall_count = count_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core.
- Tracks in-flight register writers in an internal producer shift register, DEPTH slots past EX. Slot 1 is EX/MEM and slot 2 is MEM/WB.
- Produces bypass selects for NUM_SRC EX-stage operands, and a bypass select for a fixed register (x17, read by ecall in ID).
- Generates the load-use stall request for ID and counts stall cycles.

Parameters:
- REG_W, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- DEPTH, 2, number of tracked producer slots past EX (1..7).
- LOAD_READY, 2, first slot whose load data may be bypassed (1..DEPTH).
- FIXED_REG, 17, register number for fwd_fixed_sel.
- CNT_W, 32, stall counter width.
- SEL_W, 3, select width; must satisfy 2^SEL_W > DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- advance  in  1  pipeline moves past EX this cycle; slots shift.
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- ex_rd  in  REG_W  destination of the EX instruction.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rs  in  NUM_SRC*REG_W  EX sources, source i at [i*REG_W +: REG_W].
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_W  ID sources.
- id_rs_used  in  NUM_SRC  per-source "actually read" flags.
- fwd_sel  out  NUM_SRC*SEL_W  per EX source: 0 = register file, k = bypass from slot k.
- fwd_fixed_sel  out  SEL_W  youngest slot writing FIXED_REG, 0 = none.
- stall_req  out  1  hold IF/ID and inject a bubble into EX.
- stall_count  out  CNT_W  saturating count of cycles with stall_req=1.

Behaviour:
- Slot state: per slot k, hold valid, rd, reg_write, mem_read.
- On a rising edge with reset=0: all slot valid bits and stall_count clear to 0. Outputs therefore read fwd_sel=0, fwd_fixed_sel=0, stall_req=0, stall_count=0 from the next cycle onward.
- Reset overrides advance and any in-flight contents; there is no partial flush.
- When advance=1, slots shift: slot k+1 ← slot k, and slot 1 ← {ex_valid, ex_rd, ex_reg_write, ex_mem_read}. The slot DEPTH contents are dropped.
- When advance=0, all slots hold.
- A slot matches register r when: valid=1, reg_write=1, rd==r, and r!=0. Register x0 never matches.
- fwd_sel, source i: the lowest k (youngest producer) whose slot matches ex_rs[i]; 0 if no slot matches.
  - Combinational from current slot state and ex_rs; zero latency.
  - Applied regardless of mem_read; the stall guarantees load data is ready.
- fwd_fixed_sel: same priority rule against FIXED_REG; combinational.
- stall_req (combinational):
  - Producer set P = the EX instruction (stage 0, valid=ex_valid) plus slots 1..DEPTH-1, each at stage j.
  - For each ID source i with id_valid=1 and id_rs_used[i]=1, take the youngest matching producer in P.
  - Assert stall_req if that producer has mem_read=1 and j+1 < LOAD_READY.
  - Only the youngest match counts: an older load shadowed by a younger ALU write does not stall.
- stall_count: increments by 1 each cycle stall_req=1; saturates at all-ones (no wrap).
- Simultaneous cases:
  - Both sources matching different slots are resolved independently.
  - Same rd in two slots: the youngest wins.
  - advance=0 with stall_req=1: the stall remains asserted and the counter keeps counting.

Test Plan:
1. Reset: drive reset=0 for 2 cycles with arbitrary inputs, then release. → All outputs 0; no stale slot matches.
2. EX→EX bypass: cycle 0 EX add x5 (ex_valid=1, ex_reg_write=1, ex_rd=5), advance=1. Cycle 1 ex_rs[0]=5. → fwd_sel[0]=1. Advance again → fwd_sel[0]=2. One more advance with DEPTH=2 → 0.
3. Priority and x0: slot 1 rd=7, slot 2 rd=7, ex_rs={7,0}; also slot 1 rd=0 with reg_write=1. → fwd_sel[0]=1, fwd_sel[1]=0.
4. Load-use: EX lw x9 (ex_mem_read=1), ID id_rs[1]=9, id_rs_used=2'b10, LOAD_READY=2. → stall_req=1 for exactly one cycle (after advance the load is in slot 1, j+1=2). stall_count=1. With id_rs_used[1]=0 → no stall.
5. Fixed register: slot 2 rd=17, then slot 1 rd=17. → fwd_fixed_sel goes 2, then 1. A write with reg_write=0 to rd=17 → 0.
6. Saturation and parameters: CNT_W=4 with stall held 20 cycles → stall_count=15. Rerun scenario 2 with DEPTH=4, LOAD_READY=3 → selects 1..4; load-use stalls 2 cycles.
